// File: rtl/pulse_meter_pkg.sv
// pulse_meter_pkg: shared types and helpers for the multi-channel pulse-width meter
package pulse_meter_pkg;
    // Result fields are sized for the widest supported counters; narrower builds zero-extend
    localparam int PM_CNT_W = 32;
    localparam int PM_TIME_W = 32;
    typedef enum logic [1:0] {IDLE, MEASURE, DONE} pm_state_e;
    typedef struct packed {
        logic [PM_CNT_W-1:0] count;
        logic [PM_TIME_W-1:0] time_ms;
        logic ovf;
    } pm_result_t;
    function automatic int ms_prescale(input int clk_hz);
        return clk_hz >= 2000 ? clk_hz / 1000 : 1;
    endfunction
endpackage

// File: rtl/pulse_meter_channel.sv
// pulse_meter_channel: synchronises, edge-detects and times one pulse input
module pulse_meter_channel
    import pulse_meter_pkg::*;
#(
    parameter int CNT_W = 20,
    parameter int TIME_W = 32,
    parameter int CLK_HZ = 50_000_000,
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       pulse_in,
    input  logic       en,
    input  logic       pol,
    output logic       busy,
    output logic       done_tick,
    output logic       store,
    output pm_result_t result
);
    localparam int M = ms_prescale(CLK_HZ);
    localparam int PRE_W = M > 1 ? $clog2(M) : 1;
    pm_state_e state, state_nx;
    logic [SYNC_STAGES-1:0] sync;
    logic act_q, pol_q, pol_eff, active, start, wrap, ovf;
    logic [CNT_W-1:0] cnt;
    logic [PRE_W-1:0] pre;
    logic [TIME_W-1:0] ms;
    assign pol_eff = state == IDLE ? pol : pol_q;
    assign active = sync[SYNC_STAGES-1] ^ ~pol_eff;
    assign start = en & active & ~act_q;
    assign wrap = pre == PRE_W'(M - 1);
    assign busy = state == MEASURE;
    assign store = state == DONE;
    always_comb begin
        state_nx = state == IDLE ? (start ? MEASURE : IDLE)
                 : state == MEASURE ? (!en ? IDLE : active ? MEASURE : DONE)
                 : IDLE;
    end
    always_ff @(posedge clk) begin
        state <= rst ? IDLE : state_nx;
    end
    // Reset preloads the pin level and marks it seen, so a pulse already active is ignored
    always_ff @(posedge clk) begin
        sync <= rst ? {SYNC_STAGES{pulse_in}} : {sync[SYNC_STAGES-2:0], pulse_in};
        act_q <= rst | active;
        pol_q <= pol_eff;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
            pre <= '0;
            ms <= '0;
            ovf <= 1'b0;
            result <= '0;
            done_tick <= 1'b0;
        end else begin
            done_tick <= store;
            if (store) result <= {PM_CNT_W'(cnt), PM_TIME_W'(ms), ovf};
            if (state == IDLE && start) begin
                cnt <= CNT_W'(1);
                pre <= PRE_W'(M > 1 ? 1 : 0);
                ms <= TIME_W'(M > 1 ? 0 : 1);
                ovf <= 1'b0;
            end else if (busy && active) begin
                cnt <= &cnt ? cnt : cnt + 1'b1;
                pre <= wrap ? '0 : pre + 1'b1;
                if (wrap) ms <= &ms ? ms : ms + 1'b1;
                ovf <= ovf | &cnt | (wrap & &ms);
            end
        end
    end
endmodule

// File: rtl/pulse_width_meter_mc.sv
// pulse_width_meter_mc: multi-channel pulse-width meter with shared read port
module pulse_width_meter_mc
    import pulse_meter_pkg::*;
#(
    parameter int CHANNELS = 4,
    parameter int CNT_W = 20,
    parameter int TIME_W = 32,
    parameter int CLK_HZ = 50_000_000,
    parameter int SYNC_STAGES = 2,
    localparam int CH_W = CHANNELS > 1 ? $clog2(CHANNELS) : 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [CHANNELS-1:0] pulse_in,
    input  logic [CHANNELS-1:0] ch_en,
    input  logic [CHANNELS-1:0] pol,
    input  logic                rd_req,
    input  logic [CH_W-1:0]     rd_ch,
    output logic [CHANNELS-1:0] busy,
    output logic [CHANNELS-1:0] done_tick,
    output logic [CHANNELS-1:0] fresh,
    output logic                rd_valid,
    output logic [CNT_W-1:0]    rd_count,
    output logic [TIME_W-1:0]   rd_time_ms,
    output logic                rd_ovf
);
    pm_result_t result [CHANNELS];
    pm_result_t sel;
    logic [CHANNELS-1:0] store, clr;
    logic hit, unused_sel;
    assign hit = 32'(rd_ch) < CHANNELS;
    assign sel = hit ? result[rd_ch] : '0;
    assign clr = (rd_req && hit) ? CHANNELS'(1) << rd_ch : '0;
    assign unused_sel = ^sel;
    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        pulse_meter_channel #(
            .CNT_W(CNT_W), .TIME_W(TIME_W), .CLK_HZ(CLK_HZ), .SYNC_STAGES(SYNC_STAGES)
        ) u_ch (
            .clk(clk), .rst(rst), .pulse_in(pulse_in[i]), .en(ch_en[i]), .pol(pol[i]),
            .busy(busy[i]), .done_tick(done_tick[i]), .store(store[i]), .result(result[i])
        );
    end
    // A completion in the same cycle as a read keeps fresh set; the read sees the old result
    always_ff @(posedge clk) begin
        if (rst) begin
            fresh <= '0;
            rd_valid <= 1'b0;
            rd_count <= '0;
            rd_time_ms <= '0;
            rd_ovf <= 1'b0;
        end else begin
            fresh <= store | (fresh & ~clr);
            rd_valid <= rd_req;
            if (rd_req) begin
                rd_count <= sel.count[CNT_W-1:0];
                rd_time_ms <= sel.time_ms[TIME_W-1:0];
                rd_ovf <= sel.ovf;
            end
        end
    end
endmodule

// File: tb/tb_pulse_width_meter_mc.sv
// tb_pulse_width_meter_mc: table, random and corner-case checks for the pulse-width meter
module tb_pulse_width_meter_mc;
    localparam int CHANNELS = 4, CNT_W = 10, TIME_W = 4, CLK_HZ = 50_000, SYNC_STAGES = 2;
    localparam int M = CLK_HZ / 1000;
    localparam int CMAX = (1 << CNT_W) - 1, TMAX = (1 << TIME_W) - 1;

    logic clk = 0, rst = 1, rd_req = 0;
    logic [CHANNELS-1:0] pulse_in = '0, ch_en = '1, pol = '1;
    logic [1:0] rd_ch = '0;
    logic [CHANNELS-1:0] busy, done_tick, fresh;
    logic rd_valid, rd_ovf;
    logic [CNT_W-1:0] rd_count;
    logic [TIME_W-1:0] rd_time_ms;
    int n_chk = 0, n_pass = 0;
    int exp_cnt [CHANNELS], exp_ms [CHANNELS], exp_ovf [CHANNELS], exp_fresh [CHANNELS];

    typedef struct { int ch; int p; int w; int cnt; int ms; int ovf; } vec_t;
    vec_t vecs [12];

    always #5 clk = ~clk;

    pulse_width_meter_mc #(
        .CHANNELS(CHANNELS), .CNT_W(CNT_W), .TIME_W(TIME_W), .CLK_HZ(CLK_HZ), .SYNC_STAGES(SYNC_STAGES)
    ) dut (
        .clk(clk), .rst(rst), .pulse_in(pulse_in), .ch_en(ch_en), .pol(pol),
        .rd_req(rd_req), .rd_ch(rd_ch), .busy(busy), .done_tick(done_tick), .fresh(fresh),
        .rd_valid(rd_valid), .rd_count(rd_count), .rd_time_ms(rd_time_ms), .rd_ovf(rd_ovf)
    );

    task automatic chk(input string name, input longint act, input longint exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic set_pol(input int ch, input int p);
        @(negedge clk);
        ch_en[ch] = 1'b0;
        pol[ch] = p[0];
        pulse_in[ch] = ~p[0];
        repeat (4) @(negedge clk);
        ch_en[ch] = 1'b1;
    endtask

    task automatic run_pulse(input int ch, input int w);
        pulse_in[ch] = pol[ch];
        for (int i = 1; i <= w; i++) begin
            @(negedge clk);
            if (w >= 4 && (i == 2 || i == 3)) chk("busy_lead", busy[ch], i == 3);
        end
        pulse_in[ch] = ~pol[ch];
    endtask

    task automatic wait_done(input int ch);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!done_tick[ch] && n < 20);
        chk("done_latency", n, 4);
        chk("fresh_set", fresh[ch], 1);
    endtask

    task automatic watch_none(input int ch, input int cycles);
        int k = 0;
        repeat (cycles) begin
            @(negedge clk);
            if (done_tick[ch]) k++;
        end
        chk("no_done_tick", k, 0);
    endtask

    task automatic expect_res(input int ch, input int c, input int m, input int o);
        exp_cnt[ch] = c;
        exp_ms[ch] = m;
        exp_ovf[ch] = o;
        exp_fresh[ch] = 1;
    endtask

    task automatic model(input int w, output int c, output int m, output int o);
        c = w > CMAX ? CMAX : w;
        m = w / M > TMAX ? TMAX : w / M;
        o = int'(w > CMAX || w / M > TMAX);
    endtask

    task automatic do_read(input int ch);
        rd_req = 1'b1;
        rd_ch = 2'(ch);
        @(negedge clk);
        rd_req = 1'b0;
        chk("rd_valid", rd_valid, 1);
        chk("rd_count", rd_count, exp_cnt[ch]);
        chk("rd_time_ms", rd_time_ms, exp_ms[ch]);
        chk("rd_ovf", rd_ovf, exp_ovf[ch]);
        chk("fresh_clear", fresh[ch], 0);
        chk("done_one_cycle", done_tick[ch], 0);
        exp_fresh[ch] = 0;
    endtask

    initial begin
        int c, m, o, ch, p, w, b;
        vecs[0]  = '{ch: 0, p: 1, w: 100,  cnt: 100,  ms: 2,  ovf: 0};
        vecs[1]  = '{ch: 2, p: 1, w: 100,  cnt: 100,  ms: 2,  ovf: 0};
        vecs[2]  = '{ch: 2, p: 1, w: 200,  cnt: 200,  ms: 4,  ovf: 0};
        vecs[3]  = '{ch: 2, p: 1, w: 50,   cnt: 50,   ms: 1,  ovf: 0};
        vecs[4]  = '{ch: 2, p: 1, w: 150,  cnt: 150,  ms: 3,  ovf: 0};
        vecs[5]  = '{ch: 2, p: 1, w: 250,  cnt: 250,  ms: 5,  ovf: 0};
        vecs[6]  = '{ch: 1, p: 0, w: 49,   cnt: 49,   ms: 0,  ovf: 0};
        vecs[7]  = '{ch: 3, p: 1, w: 1034, cnt: 1023, ms: 15, ovf: 1};
        vecs[8]  = '{ch: 1, p: 1, w: 1,    cnt: 1,    ms: 0,  ovf: 0};
        vecs[9]  = '{ch: 3, p: 0, w: 899,  cnt: 899,  ms: 15, ovf: 1};
        vecs[10] = '{ch: 0, p: 0, w: 99,   cnt: 99,   ms: 1,  ovf: 0};
        vecs[11] = '{ch: 1, p: 1, w: 750,  cnt: 750,  ms: 15, ovf: 0};
        for (int i = 0; i < CHANNELS; i++) begin
            exp_cnt[i] = 0; exp_ms[i] = 0; exp_ovf[i] = 0; exp_fresh[i] = 0;
        end
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("reset_outputs", {busy, done_tick, fresh, rd_valid, rd_count, rd_time_ms, rd_ovf}, 0);

        for (int i = 0; i < 12; i++) begin
            set_pol(vecs[i].ch, vecs[i].p);
            run_pulse(vecs[i].ch, vecs[i].w);
            wait_done(vecs[i].ch);
            expect_res(vecs[i].ch, vecs[i].cnt, vecs[i].ms, vecs[i].ovf);
            do_read(vecs[i].ch);
        end

        for (int i = 0; i < 12; i++) begin
            ch = int'($urandom_range(0, 3));
            p = int'($urandom_range(0, 1));
            w = int'($urandom_range(1, 1100));
            set_pol(ch, p);
            run_pulse(ch, w);
            wait_done(ch);
            model(w, c, m, o);
            expect_res(ch, c, m, o);
            do_read(ch);
        end

        for (int i = 0; i < CHANNELS; i++) set_pol(i, 1);
        @(negedge clk);
        pulse_in = '1;
        repeat (60) @(negedge clk);
        pulse_in = '0;
        repeat (3) @(negedge clk);
        chk("sim_busy_done_state", busy, 0);
        chk("sim_no_early_tick", done_tick, 0);
        rd_req = 1'b1;
        rd_ch = 2'd3;
        @(negedge clk);
        rd_req = 1'b0;
        chk("sim_done_all", done_tick, 4'hF);
        chk("sim_fresh_all", fresh, 4'hF);
        chk("sim_rd_valid", rd_valid, 1);
        chk("sim_rd_old_count", rd_count, exp_cnt[3]);
        chk("sim_rd_old_ms", rd_time_ms, exp_ms[3]);
        chk("sim_rd_old_ovf", rd_ovf, exp_ovf[3]);
        model(60, c, m, o);
        for (int i = 0; i < CHANNELS; i++) expect_res(i, c, m, o);
        do_read(3);

        set_pol(0, 1);
        pulse_in[0] = 1'b1;
        repeat (30) @(negedge clk);
        chk("abort_busy_before", busy[0], 1);
        ch_en[0] = 1'b0;
        @(negedge clk);
        chk("abort_busy_after", busy[0], 0);
        pulse_in[0] = 1'b0;
        watch_none(0, 10);
        ch_en[0] = 1'b1;
        chk("abort_fresh_kept", fresh[0], exp_fresh[0]);
        do_read(0);

        set_pol(1, 1);
        ch_en[1] = 1'b0;
        pulse_in[1] = 1'b1;
        repeat (5) @(negedge clk);
        ch_en[1] = 1'b1;
        repeat (20) @(negedge clk);
        chk("en_rise_no_busy", busy[1], 0);
        pulse_in[1] = 1'b0;
        watch_none(1, 10);

        set_pol(1, 1);
        pulse_in[1] = 1'b1;
        repeat (20) @(negedge clk);
        chk("rst_mid_busy", busy[1], 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rst_mid_outputs", {busy, done_tick, fresh, rd_valid, rd_count, rd_time_ms, rd_ovf}, 0);
        pulse_in[1] = 1'b0;
        watch_none(1, 10);
        for (int i = 0; i < CHANNELS; i++) begin
            exp_cnt[i] = 0; exp_ms[i] = 0; exp_ovf[i] = 0; exp_fresh[i] = 0;
        end
        do_read(2);

        set_pol(2, 1);
        pulse_in[2] = 1'b1;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        b = 0;
        repeat (20) begin
            @(negedge clk);
            if (busy[2]) b++;
        end
        chk("held_high_no_busy", b, 0);
        pulse_in[2] = 1'b0;
        watch_none(2, 10);
        set_pol(2, 1);
        run_pulse(2, 75);
        wait_done(2);
        model(75, c, m, o);
        expect_res(2, c, m, o);
        do_read(2);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/pulse_width_meter_mc.md
# pulse_width_meter_mc

Multi-channel, parametrised pulse-width meter. It measures the width of active pulses on `CHANNELS` asynchronous inputs, in clock cycles and in whole milliseconds, with per-channel polarity and enable. Each channel keeps its last completed result with a sticky "fresh" flag. A shared, channel-addressed read port returns results to the host-side register block. It replaces the single-channel counter in the timing-capture subsystem.

## Interface
- `CHANNELS`, 4, number of independent input channels (1..16)
- `CNT_W`, 20, width of the cycle counter; the count saturates at all-ones
- `TIME_W`, 32, width of the millisecond result
- `CLK_HZ`, 50_000_000, clock frequency; one ms equals `CLK_HZ/1000` cycles
- `SYNC_STAGES`, 2, synchroniser depth on `pulse_in` (≥2)
- `CH_W`, `$clog2(CHANNELS)` (min 1), derived localparam, not overridable

Reset: one clock; reset is synchronous and active-high (`clk`, `rst`).

- `clk`  in  1  system clock
- `rst`  in  1  synchronous active-high reset
- `pulse_in`  in  CHANNELS  asynchronous pulse inputs
- `ch_en`  in  CHANNELS  per-channel enable
- `pol`  in  CHANNELS  1 = measure high pulses, 0 = measure low pulses
- `rd_req`  in  1  read strobe, one cycle
- `rd_ch`  in  CH_W  channel to read
- `busy`  out  CHANNELS  channel is in MEASURE
- `done_tick`  out  CHANNELS  one-cycle pulse when a result is stored
- `fresh`  out  CHANNELS  sticky: unread result present
- `rd_valid`  out  1  read data valid, one cycle
- `rd_count`  out  CNT_W  stored cycle count
- `rd_time_ms`  out  TIME_W  stored width in whole ms
- `rd_ovf`  out  1  stored result saturated

## Operation
- Input path per channel: `SYNC_STAGES`-flop synchroniser. The synchronised level is XORed with `~pol` to give "active". An edge detector follows.
- Per-channel FSM:
  - IDLE→MEASURE on an inactive→active edge while `ch_en`=1.
  - MEASURE→DONE on an active→inactive edge.
  - DONE→IDLE unconditionally after one cycle.
- MEASURE:
  - `cnt` increments every active cycle.
  - Prescaler counts 0..`CLK_HZ/1000`-1; on wrap, `ms` increments.
  - `cnt`, prescaler and `ms` clear on entry.
- Result equals the number of synchronised active cycles. `time_ms` = floor(`cnt` / (`CLK_HZ/1000`)).
- Saturation:
  - `cnt` and `ms` hold at all-ones and never wrap.
  - `ovf` is set if either saturates.
  - The measurement still ends normally on the trailing edge.
- DONE:
  - Result {`cnt`, `ms`, `ovf`} is copied into the per-channel result register.
  - `fresh` is set and `done_tick` pulses.
- An input already active when `rst` releases, or when `ch_en` rises, is not measured. An inactive→active edge is required.
- `ch_en` deasserted in MEASURE aborts to IDLE: no result, no `done_tick`, stored result untouched.
- `pol` is sampled only in IDLE. A change during MEASURE takes effect in the next IDLE.
- Read:
  - `rd_req` returns the stored result of `rd_ch` and clears that channel's `fresh`.
  - `rd_ch` ≥ `CHANNELS`: `rd_valid` still pulses, data reads as zero, no state change.
- Simultaneous DONE and read on the same channel: the read returns the prior stored result, the new result is stored, and `fresh` stays 1.
- Channels are fully independent. Simultaneous completions on all channels are each stored with no loss.

## Timing
- Reset values: all outputs 0, all FSMs IDLE, all result registers 0.
- Trailing edge at pin → `done_tick`: `SYNC_STAGES`+2 cycles. `busy` rises `SYNC_STAGES`+1 cycles after the leading edge.
- `fresh` rises in the same cycle as `done_tick`.
- `rd_req` at cycle t → `rd_valid` and data at t+1. Data holds until the next read. The cleared `fresh` is visible at t+1.
- `rd_req` may be asserted every cycle. No backpressure.
- Minimum measurable pulse is 1 synchronised cycle, giving `cnt`=1. Minimum gap between pulses is 2 cycles (DONE occupies one cycle). An edge arriving during DONE is lost.
- `rst` mid-measurement: all channels go to IDLE, results and `fresh` clear, and no `done_tick` is produced.

## Structure
- Package `pulse_meter_pkg`:
  - `pm_state_e` {IDLE, MEASURE, DONE}
  - `pm_result_t` struct {count, time_ms, ovf}, parametrised via package localparams `PM_CNT_W` and `PM_TIME_W`
  - ms-prescale helper function
- Sub-module `pulse_meter_channel`: synchroniser, polarity, edge detect, FSM, counters, result register. The top instantiates `CHANNELS` copies and contains the read mux plus `fresh` handling.

## Test plan
- Channel 0, `pol`=1, 100_000-cycle high pulse, then read: `done_tick[0]` at trailing edge+4; `rd_count`=100_000, `rd_time_ms`=2, `rd_ovf`=0; `fresh[0]` goes 1 then 0.
- Five sequential pulses on channel 2 of 100k, 200k, 50k, 150k and 250k cycles: reads return 2, 4, 1, 3 and 5 ms respectively, with exact counts.
- Channel 1, `pol`=0, a 49_999-cycle low pulse: `rd_count`=49_999, `rd_time_ms`=0.
- A 2^20+10-cycle pulse: `rd_count`=0xFFFFF, `rd_ovf`=1; `done_tick` fires only at the trailing edge.
- All four channels end pulses in the same cycle, and a read of channel 3 is issued in its DONE cycle: all `done_tick` bits fire; the read returns the old channel-3 data; `fresh`=4'b1111.
- Abort and reset cases:
  - `ch_en[0]` dropped mid-pulse: no `done_tick`, and the prior result is still readable.
  - `rst` mid-pulse: all outputs 0.
  - Input held high through reset release: no measurement.
